// File: rtl/seven_seg_scan_capture_pkg.sv
// Glyph table and state encodings shared by the seven-segment capture and the LED driver.
// Segment order is {A,B,C,D,E,F,G}, active-low (0 = lit).
package seven_seg_scan_capture_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;
    localparam logic [6:0] BLANK   = 7'h7F;

    localparam int NUM_DIGITS = 4;
    localparam int BUS_W      = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } bus_t;

endpackage

// File: rtl/seven_seg_scan_capture_decode.sv
// Combinational seven-segment pattern to hex decoder.
// Flags blank (all segments dark) separately from non-glyph patterns.
module seven_seg_decode
    import seven_seg_scan_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic       blank,
    output logic [3:0] hex
);

    always_comb begin
        valid = 1'b1;
        hex   = 4'h0;
        blank = (seg == BLANK);
        case (seg)
            GLYPH_0: hex = 4'h0;
            GLYPH_1: hex = 4'h1;
            GLYPH_2: hex = 4'h2;
            GLYPH_3: hex = 4'h3;
            GLYPH_4: hex = 4'h4;
            GLYPH_5: hex = 4'h5;
            GLYPH_6: hex = 4'h6;
            GLYPH_7: hex = 4'h7;
            GLYPH_8: hex = 4'h8;
            GLYPH_9: hex = 4'h9;
            GLYPH_A: hex = 4'hA;
            GLYPH_B: hex = 4'hB;
            GLYPH_C: hex = 4'hC;
            GLYPH_D: hex = 4'hD;
            GLYPH_E: hex = 4'hE;
            GLYPH_F: hex = 4'hF;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Receive side of a scanned 4-digit seven-segment bus; rebuilds 16-bit frames.
// Optional SEG_CAPTURE_DP_EN stores the per-digit decimal point into dp_out.
module seven_seg_scan_capture
    import seven_seg_scan_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        an3,
    input  logic        an2,
    input  logic        an1,
    input  logic        an0,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    input  logic        E,
    input  logic        F,
    input  logic        G,
    input  logic        dp,
    output logic [15:0] chars,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        multi_an_err,
    output logic [3:0]  dp_out
);

    localparam logic [CNT_W-1:0] CAP_AT  = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bus_t             raw;
    bus_t             s1;
    bus_t             s2;
    bus_t             prev;
    logic [CNT_W-1:0] cnt;
    logic             same;
    logic             cap;

    logic [3:0]       an_act;
    logic [2:0]       n_act;
    logic [1:0]       idx;

    logic             dec_valid;
    logic             dec_blank;
    logic [3:0]       dec_hex;

    logic             wr;
    logic             bad;
    logic             multi;
    logic             emit;

    logic [3:0][3:0]  digits;
    logic [3:0]       seen;
    logic [3:0]       seen_nxt;
    state_t           state;
    state_t           state_nxt;

    assign raw = '{an: {an3, an2, an1, an0},
                   seg: {A, B, C, D, E, F, G},
                   dp: dp};

    // Idle bus level (everything dark) so reset release looks like no activity
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    assign same = (s2 == prev);
    assign cap  = same && (cnt == CAP_AT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= '1;
            cnt  <= '0;
        end else begin
            prev <= s2;
            if (!same)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign an_act = ~s2.an;

    always_comb begin
        n_act = 3'd0;
        idx   = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            n_act = n_act + 3'(an_act[i]);
            if (an_act[i])
                idx = 2'(i);
        end
    end

    seven_seg_decode u_dec (
        .seg   (s2.seg),
        .valid (dec_valid),
        .blank (dec_blank),
        .hex   (dec_hex)
    );

    assign wr    = cap && (n_act == 3'd1) && dec_valid;
    assign bad   = cap && (n_act == 3'd1) && !dec_valid && !dec_blank;
    assign multi = cap && (n_act > 3'd1);
    assign emit  = (state == ST_EMIT);

    // EMIT clears seen first, so a capture in that cycle starts the next frame
    always_comb begin
        seen_nxt = emit ? 4'b0000 : seen;
        if (wr)
            seen_nxt[idx] = 1'b1;
        if (bad)
            seen_nxt[idx] = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (wr)
                    state_nxt = ST_TRACK;
            end
            ST_TRACK: begin
                if (seen_nxt == 4'b1111)
                    state_nxt = ST_EMIT;
            end
            ST_EMIT: state_nxt = ST_TRACK;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            seen  <= 4'b0000;
        end else begin
            state <= state_nxt;
            seen  <= seen_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits <= '0;
        end else if (wr) begin
            digits[idx] <= dec_hex;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chars        <= 16'h0000;
            frame_valid  <= 1'b0;
            seg_err      <= 1'b0;
            multi_an_err <= 1'b0;
        end else begin
            frame_valid  <= emit;
            seg_err      <= bad;
            multi_an_err <= multi;
            if (emit)
                chars <= digits;
        end
    end

`ifdef SEG_CAPTURE_DP_EN
    logic [3:0] dp_reg;
    logic [3:0] dp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_reg <= 4'b0000;
            dp_q   <= 4'b0000;
        end else begin
            if (wr)
                dp_reg[idx] <= ~s2.dp;
            if (emit)
                dp_q <= dp_reg;
        end
    end

    assign dp_out = dp_q;
`else
    assign dp_out = 4'b0000;
`endif

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed bench for seven_seg_scan_capture.
// Build with +define+SEG_CAPTURE_DP_EN to exercise dp capture.
module tb_seven_seg_scan_capture;

    logic        clk;
    logic        rst_n;
    logic        an3, an2, an1, an0;
    logic        A, B, C, D, E, F, G;
    logic        dp;
    logic [15:0] chars;
    logic        frame_valid;
    logic        seg_err;
    logic        multi_an_err;
    logic [3:0]  dp_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fv_cnt, se_cnt, ma_cnt, fv_cyc;
    logic [15:0] fv_first, fv_chars;
    logic [3:0]  fv_dp;

    seven_seg_scan_capture dut (
        .clk          (clk),
        .reset        (rst_n),
        .an3          (an3),
        .an2          (an2),
        .an1          (an1),
        .an0          (an0),
        .A            (A),
        .B            (B),
        .C            (C),
        .D            (D),
        .E            (E),
        .F            (F),
        .G            (G),
        .dp           (dp),
        .chars        (chars),
        .frame_valid  (frame_valid),
        .seg_err      (seg_err),
        .multi_an_err (multi_an_err),
        .dp_out       (dp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] gl(input logic [3:0] h);
        case (h)
            4'h0: gl = 7'b0000001;
            4'h1: gl = 7'b1001111;
            4'h2: gl = 7'b0010010;
            4'h3: gl = 7'b0000110;
            4'h4: gl = 7'b1001100;
            4'h5: gl = 7'b0100100;
            4'h6: gl = 7'b0100000;
            4'h7: gl = 7'b0001111;
            4'h8: gl = 7'b0000000;
            4'h9: gl = 7'b0000100;
            4'hA: gl = 7'b0001000;
            4'hB: gl = 7'b1100000;
            4'hC: gl = 7'b0110001;
            4'hD: gl = 7'b1000010;
            4'hE: gl = 7'b0110000;
            default: gl = 7'b0111000;
        endcase
    endfunction

    task automatic clear_counts();
        fv_cnt = 0;
        se_cnt = 0;
        ma_cnt = 0;
        fv_cyc = -1;
        fv_first = 16'hxxxx;
        fv_chars = 16'hxxxx;
        fv_dp = 4'bxxxx;
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s,
                         input logic d, input int n);
        {an3, an2, an1, an0} = a;
        {A, B, C, D, E, F, G} = s;
        dp = d;
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (frame_valid) begin
                fv_cnt++;
                fv_cyc = cyc;
                if (fv_cnt == 1)
                    fv_first = chars;
                fv_chars = chars;
                fv_dp = dp_out;
            end
            if (seg_err)
                se_cnt++;
            if (multi_an_err)
                ma_cnt++;
        end
    endtask

    task automatic dig(input int i, input logic [3:0] h, input int n);
        logic [3:0] a;
        a = 4'b1111;
        a[i] = 1'b0;
        dwell(a, gl(h), 1'b1, n);
    endtask

    task automatic scan(input logic [15:0] v, input int n, input logic [3:0] dpm);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a;
            a = 4'b1111;
            a[i] = 1'b0;
            dwell(a, gl(v[i*4 +: 4]), ~dpm[i], n);
        end
    endtask

    task automatic flush();
        dwell(4'b1111, 7'h7F, 1'b1, 10);
    endtask

    task automatic test_reset();
        tests++;
        if (chars !== 16'h0000) begin
            fails++;
            $display("FAIL rst_chars got %h want 0000", chars);
        end
        tests++;
        if ({frame_valid, seg_err, multi_an_err} !== 3'b000) begin
            fails++;
            $display("FAIL rst_pulses got %b want 000",
                     {frame_valid, seg_err, multi_an_err});
        end
        tests++;
        if (dp_out !== 4'b0000) begin
            fails++;
            $display("FAIL rst_dp got %b want 0000", dp_out);
        end
    endtask

    task automatic test_scan();
        int start3;
        clear_counts();
        dig(0, 4'h0, 6);
        dig(1, 4'h1, 6);
        dig(2, 4'h2, 6);
        start3 = cyc;
        dig(3, 4'h3, 6);
        flush();
        tests++;
        if (fv_cnt !== 1) begin
            fails++;
            $display("FAIL scan_fv got %0d want 1", fv_cnt);
        end
        tests++;
        if (fv_chars !== 16'h3210) begin
            fails++;
            $display("FAIL scan_chars got %h want 3210", fv_chars);
        end
        tests++;
        if (fv_cyc !== start3 + 7) begin
            fails++;
            $display("FAIL scan_latency got %0d want %0d", fv_cyc, start3 + 7);
        end
        tests++;
        if (se_cnt + ma_cnt !== 0) begin
            fails++;
            $display("FAIL scan_err got %0d want 0", se_cnt + ma_cnt);
        end
    endtask

    task automatic test_short_dwell();
        clear_counts();
        scan(16'h3210, 3, 4'b0000);
        scan(16'h3210, 3, 4'b0000);
        flush();
        tests++;
        if (fv_cnt !== 0) begin
            fails++;
            $display("FAIL short_fv got %0d want 0", fv_cnt);
        end
    endtask

    task automatic test_multi_an();
        clear_counts();
        dwell(4'b1100, 7'b0000001, 1'b1, 6);
        flush();
        tests++;
        if (ma_cnt !== 1) begin
            fails++;
            $display("FAIL multi_cnt got %0d want 1", ma_cnt);
        end
        tests++;
        if (fv_cnt + se_cnt !== 0) begin
            fails++;
            $display("FAIL multi_side got %0d want 0", fv_cnt + se_cnt);
        end
    endtask

    task automatic test_seg_err();
        clear_counts();
        dig(2, 4'h5, 6);
        dig(0, 4'h0, 6);
        dig(1, 4'h1, 6);
        dwell(4'b1011, 7'b1111110, 1'b1, 6);
        dig(3, 4'h3, 6);
        flush();
        tests++;
        if (se_cnt !== 1) begin
            fails++;
            $display("FAIL segerr_cnt got %0d want 1", se_cnt);
        end
        tests++;
        if (fv_cnt !== 0) begin
            fails++;
            $display("FAIL segerr_fv got %0d want 0", fv_cnt);
        end
        clear_counts();
        scan(16'hF2BA, 6, 4'b0000);
        flush();
        tests++;
        if (fv_cnt !== 1) begin
            fails++;
            $display("FAIL segerr_fv2 got %0d want 1", fv_cnt);
        end
        tests++;
        if (fv_chars !== 16'h32BA) begin
            fails++;
            $display("FAIL segerr_chars got %h want 32ba", fv_chars);
        end
    endtask

    task automatic test_blank();
        clear_counts();
        dwell(4'b0111, 7'h7F, 1'b1, 6);
        dig(0, 4'h5, 6);
        dig(1, 4'h6, 6);
        tests++;
        if (fv_cnt + se_cnt !== 0) begin
            fails++;
            $display("FAIL blank_pre got %0d want 0", fv_cnt + se_cnt);
        end
        dig(2, 4'h8, 6);
        flush();
        tests++;
        if (fv_cnt !== 1) begin
            fails++;
            $display("FAIL blank_fv got %0d want 1", fv_cnt);
        end
        tests++;
        if (fv_chars !== 16'hF865) begin
            fails++;
            $display("FAIL blank_chars got %h want f865", fv_chars);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        scan(16'h1357, 6, 4'b0000);
        scan(16'h2468, 6, 4'b0000);
        flush();
        tests++;
        if (fv_cnt !== 2) begin
            fails++;
            $display("FAIL b2b_fv got %0d want 2", fv_cnt);
        end
        tests++;
        if (fv_first !== 16'h1357) begin
            fails++;
            $display("FAIL b2b_first got %h want 1357", fv_first);
        end
        tests++;
        if (fv_chars !== 16'h2468) begin
            fails++;
            $display("FAIL b2b_last got %h want 2468", fv_chars);
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        dig(0, 4'h9, 6);
        dig(1, 4'hE, 6);
        dwell(4'b1111, 7'h7F, 1'b1, 1);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({chars, frame_valid, seg_err, multi_an_err, dp_out} !== 23'd0) begin
            fails++;
            $display("FAIL midrst_out got %h/%b%b%b/%b want 0",
                     chars, frame_valid, seg_err, multi_an_err, dp_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        dig(2, 4'h7, 6);
        dig(3, 4'hD, 6);
        flush();
        tests++;
        if (fv_cnt !== 0) begin
            fails++;
            $display("FAIL midrst_fv0 got %0d want 0", fv_cnt);
        end
        dig(0, 4'h1, 6);
        dig(1, 4'h0, 6);
        flush();
        tests++;
        if (fv_cnt !== 1) begin
            fails++;
            $display("FAIL midrst_fv1 got %0d want 1", fv_cnt);
        end
        tests++;
        if (fv_chars !== 16'hD701) begin
            fails++;
            $display("FAIL midrst_chars got %h want d701", fv_chars);
        end
    endtask

    task automatic test_dp();
        logic [3:0] want;
`ifdef SEG_CAPTURE_DP_EN
        want = 4'b0010;
`else
        want = 4'b0000;
`endif
        clear_counts();
        scan(16'h3210, 6, 4'b0010);
        flush();
        tests++;
        if (fv_cnt !== 1) begin
            fails++;
            $display("FAIL dp_fv got %0d want 1", fv_cnt);
        end
        tests++;
        if (fv_dp !== want) begin
            fails++;
            $display("FAIL dp_out got %b want %b", fv_dp, want);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {an3, an2, an1, an0} = 4'b1111;
        {A, B, C, D, E, F, G} = 7'h7F;
        dp = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_scan();
        test_short_dwell();
        test_multi_an();
        test_seg_err();
        test_blank();
        test_back_to_back();
        test_reset_mid();
        test_dp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
